// File: rtl/bra_rs_pkg.sv
// Shared widths, op codes and entry layouts for the branch reservation station.
package bra_rs_pkg;

   localparam int XLEN            = 32;
   localparam int BRA_OP_WIDTH    = 4;
   localparam int ROB_ENTRY_WIDTH = 4;
   localparam int BRA_RS_DEPTH    = 4;

   typedef enum logic [BRA_OP_WIDTH-1:0] {
      OP_NOP  = 4'd0,
      OP_BEQ  = 4'd1,
      OP_BNE  = 4'd2,
      OP_BLT  = 4'd3,
      OP_BGE  = 4'd4,
      OP_BLTU = 4'd5,
      OP_BGEU = 4'd6,
      OP_JAL  = 4'd7,
      OP_JALR = 4'd8
   } bra_op_e;

   typedef struct packed {
      bra_op_e                    op;
      logic [XLEN-1:0]            pc;
      logic [XLEN-1:0]            offset;
      logic [ROB_ENTRY_WIDTH-1:0] dest;
      logic [XLEN-1:0]            vj;
      logic [XLEN-1:0]            vk;
      logic                       wait_j;
      logic                       wait_k;
      logic [ROB_ENTRY_WIDTH-1:0] qj;
      logic [ROB_ENTRY_WIDTH-1:0] qk;
   } rs_entry_t;

   typedef struct packed {
      bra_op_e                    op;
      logic [XLEN-1:0]            srca;
      logic [XLEN-1:0]            srcb;
      logic [XLEN-1:0]            pc;
      logic [XLEN-1:0]            offset;
      logic [ROB_ENTRY_WIDTH-1:0] dest;
   } iss_t;

   // Capture a CDB broadcast into whichever pending operand is waiting on its tag.
   function automatic rs_entry_t rs_snoop(input rs_entry_t                  e,
                                          input logic                       cdb_v,
                                          input logic [ROB_ENTRY_WIDTH-1:0] cdb_t,
                                          input logic [XLEN-1:0]            cdb_d);
      rs_entry_t r;
      r = e;
      if (cdb_v && e.wait_j && (e.qj == cdb_t)) begin
         r.vj     = cdb_d;
         r.wait_j = 1'b0;
      end
      if (cdb_v && e.wait_k && (e.qk == cdb_t)) begin
         r.vk     = cdb_d;
         r.wait_k = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/bra_rs_pick.sv
// Find-first-set over the ready vector: lowest index wins, i.e. the oldest entry.
module bra_rs_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o,
   output logic         any_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && !found) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/bra_rs.sv
// Branch/jump reservation station: age-ordered collapsing queue with CDB snoop
// and a registered issue port feeding the combinational branch unit.
module bra_rs
   import bra_rs_pkg::*;
#(
   parameter int DEPTH = BRA_RS_DEPTH,
   parameter int CNT_W = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [BRA_OP_WIDTH-1:0]    disp_op,
   input  logic [XLEN-1:0]            disp_pc,
   input  logic [XLEN-1:0]            disp_offset,
   input  logic [ROB_ENTRY_WIDTH-1:0] disp_dest,
   input  logic [XLEN-1:0]            disp_vj,
   input  logic [XLEN-1:0]            disp_vk,
   input  logic                       disp_qj_wait,
   input  logic                       disp_qk_wait,
   input  logic [ROB_ENTRY_WIDTH-1:0] disp_qj,
   input  logic [ROB_ENTRY_WIDTH-1:0] disp_qk,
   input  logic                       cdb_valid,
   input  logic [ROB_ENTRY_WIDTH-1:0] cdb_tag,
   input  logic [XLEN-1:0]            cdb_val,
   output logic                       iss_valid,
   output logic [BRA_OP_WIDTH-1:0]    iss_op,
   output logic [XLEN-1:0]            iss_srca,
   output logic [XLEN-1:0]            iss_srcb,
   output logic [XLEN-1:0]            iss_pc,
   output logic [XLEN-1:0]            iss_offset,
   output logic [ROB_ENTRY_WIDTH-1:0] iss_dest,
   output logic [CNT_W-1:0]           count
);

   rs_entry_t        ent_q   [DEPTH];
   rs_entry_t        ent_d   [DEPTH];
   rs_entry_t        ent_snp [DEPTH];
   rs_entry_t        new_ent;
   logic [CNT_W-1:0] count_q, count_d, cnt_mid;
   logic [DEPTH-1:0] rdy, gnt;
   logic             any_rdy;
   logic             disp_acc;
   logic             shift;
   iss_t             iss_q, iss_d;
   logic             iss_valid_q, iss_valid_d;

   assign disp_ready = (count_q < CNT_W'(DEPTH));
   assign disp_acc   = disp_valid && disp_ready && !flush && (disp_op != '0);

   // Readiness comes from registered state only, so a wake-up issues one edge later.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rdy[i]     = (CNT_W'(i) < count_q) && !ent_q[i].wait_j && !ent_q[i].wait_k;
         ent_snp[i] = rs_snoop(ent_q[i], cdb_valid, cdb_tag, cdb_val);
      end
      new_ent = rs_snoop('{op:     bra_op_e'(disp_op),
                           pc:     disp_pc,
                           offset: disp_offset,
                           dest:   disp_dest,
                           vj:     disp_vj,
                           vk:     disp_vk,
                           wait_j: disp_qj_wait,
                           wait_k: disp_qk_wait,
                           qj:     disp_qj,
                           qk:     disp_qk},
                         cdb_valid, cdb_tag, cdb_val);
   end

   bra_rs_pick #(.N(DEPTH)) u_pick (
      .req_i (rdy),
      .gnt_o (gnt),
      .any_o (any_rdy)
   );

   // NOTE: every variable in this block gets its default before any conditional
   // update, so partial paths can never infer a latch.
   always_comb begin
      shift       = 1'b0;
      iss_d       = '0;
      iss_valid_d = any_rdy;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt[i]) begin
            iss_d.op     = ent_q[i].op;
            iss_d.srca   = ent_q[i].vj;
            iss_d.srcb   = ent_q[i].vk;
            iss_d.pc     = ent_q[i].pc;
            iss_d.offset = ent_q[i].offset;
            iss_d.dest   = ent_q[i].dest;
         end
      end

      // Entries at and above the granted slot collapse down by one.
      ent_d[DEPTH-1] = ent_snp[DEPTH-1];
      for (int i = 0; i < DEPTH-1; i++) begin
         shift    = shift | gnt[i];
         ent_d[i] = shift ? ent_snp[i+1] : ent_snp[i];
      end

      cnt_mid = count_q - {{(CNT_W-1){1'b0}}, any_rdy};
      count_d = cnt_mid + {{(CNT_W-1){1'b0}}, disp_acc};
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_acc && (CNT_W'(i) == cnt_mid)) begin
            ent_d[i] = new_ent;
         end
      end

      if (flush) begin
         count_d     = '0;
         iss_valid_d = 1'b0;
         iss_d       = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_q       <= '0;
      end else begin
         count_q     <= count_d;
         iss_valid_q <= iss_valid_d;
         iss_q       <= iss_d;
      end
   end

   // NOTE: entry payload is deliberately not reset; count_q alone marks which
   // slots hold live micro-ops, so stale contents are never observed.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   assign iss_valid  = iss_valid_q;
   assign iss_op     = iss_q.op;
   assign iss_srca   = iss_q.srca;
   assign iss_srcb   = iss_q.srcb;
   assign iss_pc     = iss_q.pc;
   assign iss_offset = iss_q.offset;
   assign iss_dest   = iss_q.dest;
   assign count      = count_q;

endmodule

// File: tb/tb_bra_rs.sv
// Self-checking bench for bra_rs: queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_bra_rs;
   import bra_rs_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic        clk = 1'b0;
   logic        rst_n, flush, disp_valid, disp_ready;
   logic [3:0]  disp_op, disp_dest, disp_qj, disp_qk;
   logic [31:0] disp_pc, disp_offset, disp_vj, disp_vk;
   logic        disp_qj_wait, disp_qk_wait;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        iss_valid;
   logic [3:0]  iss_op, iss_dest;
   logic [31:0] iss_srca, iss_srcb, iss_pc, iss_offset;
   logic [CNT_W-1:0] count;

   always #5 clk = ~clk;

   bra_rs #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_dest(disp_dest),
      .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_qj_wait(disp_qj_wait), .disp_qk_wait(disp_qk_wait),
      .disp_qj(disp_qj), .disp_qk(disp_qk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_srca(iss_srca),
      .iss_srcb(iss_srcb), .iss_pc(iss_pc), .iss_offset(iss_offset),
      .iss_dest(iss_dest), .count(count)
   );

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a plain age-ordered queue ----------------
   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] pc, off;
      logic [3:0]  dest;
      logic [31:0] vj, vk;
      bit          wj, wk;
      logic [3:0]  qj, qk;
   } m_ent_t;

   m_ent_t m_q[$];
   bit     m_iv;
   m_ent_t m_ie;

   function automatic m_ent_t m_snoop(input m_ent_t e);
      m_ent_t r = e;
      if (cdb_valid && r.wj && r.qj == cdb_tag) begin r.vj = cdb_val; r.wj = 0; end
      if (cdb_valid && r.wk && r.qk == cdb_tag) begin r.vk = cdb_val; r.wk = 0; end
      return r;
   endfunction

   task automatic model_step();
      int     sel;
      bit     acc;
      m_ent_t n;
      if (!rst_n || flush) begin
         m_q.delete();
         m_iv = 0;
         m_ie = '0;
      end else begin
         acc = disp_valid && (m_q.size() < DEPTH) && (disp_op != 0);
         sel = -1;
         for (int i = 0; i < m_q.size(); i++)
            if (sel < 0 && !m_q[i].wj && !m_q[i].wk) sel = i;
         if (sel >= 0) begin
            m_iv = 1;
            m_ie = m_q[sel];
            m_q.delete(sel);
         end else begin
            m_iv = 0;
            m_ie = '0;
         end
         for (int i = 0; i < m_q.size(); i++) m_q[i] = m_snoop(m_q[i]);
         if (acc) begin
            n = '{op: disp_op, pc: disp_pc, off: disp_offset, dest: disp_dest,
                  vj: disp_vj, vk: disp_vk, wj: disp_qj_wait, wk: disp_qk_wait,
                  qj: disp_qj, qk: disp_qk};
            m_q.push_back(m_snoop(n));
         end
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         check("count", 32'(count), m_q.size());
         check("disp_ready", 32'(disp_ready), 32'(m_q.size() < DEPTH));
         check("iss_valid", 32'(iss_valid), 32'(m_iv));
         check("iss_op", 32'(iss_op), 32'(m_ie.op));
         if (m_iv) begin
            check("iss_srca", iss_srca, m_ie.vj);
            check("iss_srcb", iss_srcb, m_ie.vk);
            check("iss_pc", iss_pc, m_ie.pc);
            check("iss_offset", iss_offset, m_ie.off);
            check("iss_dest", 32'(iss_dest), 32'(m_ie.dest));
         end
      end
   end

   // ---------------- issue log for order checks ----------------
   typedef struct packed {
      logic [3:0]  dest;
      logic [31:0] srca, srcb;
   } log_t;
   log_t log_q[$];

   always @(negedge clk)
      if (rst_n === 1'b1 && iss_valid === 1'b1)
         log_q.push_back('{dest: iss_dest, srca: iss_srca, srcb: iss_srcb});

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_disp(input logic [3:0] op, input logic [31:0] pc, off,
                           input logic [3:0] dest, input logic [31:0] vj, vk,
                           input logic wj, input logic [3:0] qj,
                           input logic wk, input logic [3:0] qk);
      disp_op = op; disp_pc = pc; disp_offset = off; disp_dest = dest;
      disp_vj = vj; disp_vk = vk;
      disp_qj_wait = wj; disp_qj = qj; disp_qk_wait = wk; disp_qk = qk;
   endtask

   // Holds the request until an edge at which it is accepted (bounded).
   task automatic dispatch(input logic [3:0] op, input logic [31:0] pc, off,
                           input logic [3:0] dest, input logic [31:0] vj, vk,
                           input logic wj, input logic [3:0] qj,
                           input logic wk, input logic [3:0] qk);
      bit rdy, done;
      done = 0;
      set_disp(op, pc, off, dest, vj, vk, wj, qj, wk, qk);
      disp_valid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         rdy = disp_ready && !flush;
         @(negedge clk);
         done = rdy;
      end
      check("disp_accepted", 32'(done), 32'd1);
      disp_valid = 1'b0;
   endtask

   task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] val);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
      tick(1);
      cdb_valid = 1'b0;
   endtask

   logic [3:0] exp_full [5] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

   initial begin
      flush = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
      set_disp(OP_BEQ, 32'h40, 32'h4, 4'd15, 32'd1, 32'd1, 0, 0, 0, 0);

      // Reset with a dispatch request asserted.
      rst_n = 1'b0; disp_valid = 1'b1;
      tick(2);
      check("rst_count", 32'(count), 0);
      check("rst_iss_valid", 32'(iss_valid), 0);
      check("rst_iss_op", 32'(iss_op), 0);
      check("rst_iss_srca", iss_srca, 0);
      check("rst_iss_pc", iss_pc, 0);
      check("rst_iss_dest", 32'(iss_dest), 0);
      check("rst_disp_ready", 32'(disp_ready), 1);
      rst_n = 1'b1; disp_valid = 1'b0;
      chk_en = 1'b1;

      // Ready dispatch: issues on the second edge after acceptance.
      dispatch(OP_BEQ, 32'h100, 32'h20, 4'd3, 32'd5, 32'd5, 0, 0, 0, 0);
      check("t2_count_held", 32'(count), 1);
      check("t2_not_yet", 32'(iss_valid), 0);
      tick(1);
      check("t2_iss_valid", 32'(iss_valid), 1);
      check("t2_iss_op", 32'(iss_op), 32'(OP_BEQ));
      check("t2_srca", iss_srca, 5);
      check("t2_srcb", iss_srcb, 5);
      check("t2_pc", iss_pc, 32'h100);
      check("t2_offset", iss_offset, 32'h20);
      check("t2_dest", 32'(iss_dest), 3);
      check("t2_count", 32'(count), 0);
      tick(1);
      check("t2_one_cycle", 32'(iss_valid), 0);

      // CDB wake-up; a non-matching tag is ignored.
      dispatch(OP_BNE, 32'h200, 32'h40, 4'd4, 32'd0, 32'd9, 1, 4'd7, 0, 0);
      cdb_pulse(4'd6, 32'h66);
      check("t3_tag6_count", 32'(count), 1);
      check("t3_tag6_idle", 32'(iss_valid), 0);
      tick(1);
      check("t3_still_idle", 32'(iss_valid), 0);
      cdb_pulse(4'd7, 32'h55);
      check("t3_capture_edge", 32'(iss_valid), 0);
      tick(1);
      check("t3_iss_valid", 32'(iss_valid), 1);
      check("t3_srca", iss_srca, 32'h55);
      check("t3_srcb", iss_srcb, 9);
      check("t3_dest", 32'(iss_dest), 4);
      tick(2);

      // Age ordering with an older unready entry and a same-cycle CDB capture.
      log_q.delete();
      dispatch(OP_BLT, 32'h300, 32'h8, 4'd1, 32'd0, 32'd1, 1, 4'd2, 0, 0);
      dispatch(OP_BGE, 32'h304, 32'h8, 4'd2, 32'd7, 32'd3, 0, 0, 0, 0);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_val = 32'h99;
      dispatch(OP_BLTU, 32'h308, 32'h8, 4'd5, 32'd4, 32'd0, 0, 0, 1, 4'd9);
      cdb_valid = 1'b0;
      cdb_pulse(4'd2, 32'h22);
      tick(6);
      check("t4_log_size", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check("t4_first_dest", 32'(log_q[0].dest), 2);
         check("t4_second_dest", 32'(log_q[1].dest), 5);
         check("t4_second_srcb", log_q[1].srcb, 32'h99);
         check("t4_third_dest", 32'(log_q[2].dest), 1);
         check("t4_third_srca", log_q[2].srca, 32'h22);
      end

      // Full station: fifth request waits until an issue frees a slot.
      log_q.delete();
      for (int i = 0; i < 4; i++)
         dispatch(OP_JAL, 32'h400 + 32'(4*i), 32'h10, 4'(8+i), 32'd0, 32'd0, 1, 4'd10, 0, 0);
      check("t5_full_count", 32'(count), 4);
      check("t5_full_ready", 32'(disp_ready), 0);
      set_disp(OP_JALR, 32'h500, 32'h0, 4'd12, 32'd1, 32'd2, 0, 0, 0, 0);
      disp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("t5_blocked_count", 32'(count), 4);
      end
      cdb_pulse(4'd10, 32'hA0);
      check("t5_wake_count", 32'(count), 4);
      check("t5_wake_ready", 32'(disp_ready), 0);
      tick(1);
      check("t5_first_issue", 32'(iss_valid), 1);
      check("t5_first_dest", 32'(iss_dest), 8);
      check("t5_after_issue_count", 32'(count), 3);
      check("t5_after_issue_ready", 32'(disp_ready), 1);
      tick(1);
      disp_valid = 1'b0;
      check("t5_swap_count", 32'(count), 3);
      check("t5_second_dest", 32'(iss_dest), 9);
      tick(8);
      check("t5_drained", 32'(count), 0);
      check("t5_log_size", log_q.size(), 5);
      if (log_q.size() == 5)
         for (int i = 0; i < 5; i++) check("t5_order", 32'(log_q[i].dest), 32'(exp_full[i]));

      // Flush with a simultaneous dispatch and CDB broadcast.
      log_q.delete();
      for (int i = 0; i < 3; i++)
         dispatch(OP_BGEU, 32'h600, 32'h4, 4'(1+i), 32'd0, 32'd0, 1, 4'd13, 0, 0);
      check("t6_pre_count", 32'(count), 3);
      flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_val = 32'h13;
      set_disp(OP_BEQ, 32'h700, 32'h4, 4'd6, 32'd1, 32'd1, 0, 0, 0, 0);
      disp_valid = 1'b1;
      tick(1);
      flush = 1'b0; cdb_valid = 1'b0; disp_valid = 1'b0;
      check("t6_count", 32'(count), 0);
      check("t6_iss_valid", 32'(iss_valid), 0);
      check("t6_iss_op", 32'(iss_op), 0);
      cdb_pulse(4'd13, 32'h31);
      tick(5);
      check("t6_no_issue", log_q.size(), 0);

      // Op 0 is never accepted.
      dispatch(OP_NOP, 32'h800, 32'h4, 4'd7, 32'd1, 32'd1, 0, 0, 0, 0);
      check("t7_nop_count", 32'(count), 0);
      tick(3);
      check("t7_nop_no_issue", log_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bra_rs.md
Name: bra_rs

Overview:
- Reservation station and issue scheduler for the branch/jump unit in the out-of-order core.
- Buffers dispatched branch, JAL and JALR micro-ops until both source operands are available, capturing operands from the common data bus (CDB).
- Each cycle, issues the oldest ready entry to the combinational branch unit through a registered issue port.
- On a misprediction or exception, flushes all held entries.

Parameters:
- DEPTH, 4, number of station entries (2..8).
- CNT_W, 3, width of the occupancy counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; discard all entries and any pending issue.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept a dispatch this cycle.
- disp_op  in  BRA_OP_WIDTH  branch op code; 0 = no-op, never dispatched.
- disp_pc  in  32  instruction PC.
- disp_offset  in  32  immediate offset.
- disp_dest  in  ROB_ENTRY_WIDTH  destination ROB tag.
- disp_vj, disp_vk  in  32  operand values, valid when the matching wait bit is 0.
- disp_qj_wait, disp_qk_wait  in  1  operand j / k still pending.
- disp_qj, disp_qk  in  ROB_ENTRY_WIDTH  producer ROB tag for a pending operand.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_ENTRY_WIDTH  broadcast ROB tag.
- cdb_val  in  32  broadcast value.
- iss_valid  out  1  issue port carries a micro-op this cycle.
- iss_op  out  BRA_OP_WIDTH  forced to 0 when iss_valid = 0.
- iss_srca, iss_srcb, iss_pc, iss_offset  out  32  operands to the branch unit.
- iss_dest  out  ROB_ENTRY_WIDTH  ROB tag.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst_n = 0 at an edge): all entries invalid; count = 0; iss_valid = 0; every iss_* output = 0. disp_ready = 1 once out of reset.
- Storage is an age-ordered collapsing queue: index 0 is the oldest entry, and valid entries occupy indices 0..count-1.
- disp_ready = (count < DEPTH). It does not depend on an issue in the same cycle (no same-cycle free-slot bypass).
- Dispatch accept is disp_valid && disp_ready && !flush. A dispatch with disp_op = 0 is an upstream error and is ignored.
- Dispatch with disp_valid = 1 while disp_ready = 0 is not accepted. Upstream must hold the request stable until it is accepted.
- CDB snoop, every edge: for each valid entry with wait_j set and qj == cdb_tag while cdb_valid, capture vj = cdb_val and clear wait_j. Operand k is handled identically.
- The dispatching micro-op also snoops the CDB in its dispatch cycle, so a value broadcast on that same edge is not lost.
- An entry is ready when wait_j = 0 and wait_k = 0. Readiness is evaluated from registered state, so a CDB wake-up can issue no earlier than the following cycle.
- Issue select: the lowest-index ready entry, combinationally.
  - At the edge, the iss_* registers load that entry's fields, iss_valid is set to 1, and the entry is removed.
  - Entries above the removed one shift down by one.
  - If no entry is ready, iss_valid is set to 0 and iss_op to 0.
  - The branch unit never stalls, so iss_valid is held for exactly one cycle per micro-op.
- Simultaneous dispatch and issue: the new entry is written at index count-1 (after collapse) and count is unchanged.
- Dispatch only: count + 1. Issue only: count - 1.
- Latency:
  - Operands ready at dispatch: accepted at edge k, iss_valid high in the cycle after edge k+1.
  - Operand woken by CDB at edge k: iss_valid high after edge k+1, at the earliest.
- Ordering: among ready entries, the oldest always issues first. An older unready entry does not block a younger ready one.
- Flush has priority over everything. At the edge with flush = 1: all entries invalidated, count = 0, iss_valid = 0, iss_op = 0, and any dispatch or CDB capture in that cycle is dropped.
- Reset has priority over flush.
- Full (count = DEPTH) and issue in the same cycle: disp_ready is still 0 that cycle and becomes 1 the next cycle.
- Empty: iss_valid = 0 with no side effects.
- count never exceeds DEPTH or wraps.

Decomposition:
- defines.vh (shared): BRA_OP_WIDTH, ROB_ENTRY_WIDTH, op codes BEQ..JALR. Add `BRA_RS_DEPTH` as the default for DEPTH.
- Sub-module bra_rs_pick: parameterised find-first-set over the DEPTH ready bits. Outputs a one-hot grant plus an any-ready flag.
- Entry storage, snoop and collapse logic stay in bra_rs.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with disp_valid = 1 -> count = 0, iss_valid = 0, all iss_* = 0; disp_ready = 1 after reset.
- Ready dispatch: BEQ with vj = 5, vk = 5, pc = 0x100, offset = 0x20, dest = 3, no waits -> iss_valid = 1 for one cycle, 2 edges after accept; iss_srca = 5, iss_srcb = 5, iss_pc = 0x100, iss_dest = 3; count returns to 0.
- CDB wake-up:
  - BNE waiting on qj = 7; broadcast cdb_tag = 7, cdb_val = 0x55 -> iss_srca = 0x55, issued one cycle after the capture edge.
  - A broadcast with tag 6 is ignored.
- Age ordering: dispatch A (waits on tag 2), then B and C (both ready) -> B issues, then C; A issues after tag 2 is broadcast. Same-cycle dispatch captures a CDB value.
- Full: dispatch 4 entries all waiting -> disp_ready = 0 and count = 4. A fifth disp_valid is not accepted until an issue occurs; then disp_ready = 1 the next cycle.
- Flush: 3 valid entries, flush = 1 together with a dispatch and a CDB broadcast -> count = 0 and iss_valid = 0 next cycle; no later issue of any flushed or dropped op.
